// File: rtl/jt900h_fetch.sv
// jt900h_fetch: instruction prefetch queue filling an 8-byte window from a 16-bit bus
// Bytes above count are kept at zero so op needs no masking and appends can be OR-ed in.
module jt900h_fetch #(
    parameter int QW = 4
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        jmp,
    input  logic [23:0] jmp_addr,
    input  logic [1:0]  fetched,
    output logic [31:0] op,
    output logic        op_ok,
    output logic [23:0] pc,
    output logic [23:0] bus_addr,
    output logic        bus_rd,
    input  logic [15:0] bus_din,
    input  logic        bus_ok
);
    localparam int QB = 2*QW;
    localparam int CW = $clog2(QB+1);
    logic [8*QB-1:0] q_q, q_d, app_v;
    logic [CW-1:0]   count_q, count_d, base;
    logic [23:0]     pc_q, pc_d, faddr_q, faddr_d;
    logic            rd_q, rd_d, drop_q, drop_d, gap_q, gap_d;
    logic            done, take;
    logic [1:0]      cons, n_app;
    logic [15:0]     app_data;
    assign op       = q_q[31:0];
    assign op_ok    = count_q >= CW'(4);
    assign pc       = pc_q;
    assign bus_addr = {faddr_q[23:1], 1'b0};
    assign bus_rd   = rd_q;
    always_comb begin
        done     = rd_q && bus_ok;
        take     = done && !drop_q && !jmp;
        cons     = (op_ok && !jmp) ? fetched : 2'd0;
        n_app    = take ? (faddr_q[0] ? 2'd1 : 2'd2) : 2'd0;
        app_data = take ? (faddr_q[0] ? {8'h00, bus_din[15:8]} : bus_din) : 16'h0000;
        base     = count_q - CW'(cons);
        // shift out consumed bytes first, then place new bytes right after the survivors
        app_v    = (8*QB)'(app_data) << {base, 3'b000};
        q_d      = jmp ? '0 : ((q_q >> {cons, 3'b000}) | app_v);
        count_d  = jmp ? '0 : base + CW'(n_app);
        pc_d     = jmp ? jmp_addr : pc_q + 24'(cons);
        faddr_d  = jmp ? jmp_addr : faddr_q + 24'(n_app);
        rd_d     = done ? 1'b0 : (rd_q || (!gap_q && count_q <= CW'(QB-2)));
        drop_d   = jmp ? (rd_q && !bus_ok) : (done ? 1'b0 : drop_q);
        gap_d    = done;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= '0;
            count_q <= '0;
            pc_q    <= '0;
            faddr_q <= '0;
            rd_q    <= 1'b0;
            drop_q  <= 1'b0;
            gap_q   <= 1'b0;
        end else if (cen) begin
            q_q     <= q_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            rd_q    <= rd_d;
            drop_q  <= drop_d;
            gap_q   <= gap_d;
        end
    end
endmodule

// File: tb/tb_jt900h_fetch.sv
// tb_jt900h_fetch: directed vector bench; memory returns byte value = address[7:0]
module tb_jt900h_fetch;
    logic        rst, clk, cen, jmp, op_ok, bus_rd, bus_ok;
    logic [23:0] jmp_addr, pc, bus_addr, lat;
    logic [1:0]  fetched;
    logic [31:0] op;
    logic [15:0] bus_din;
    logic [23:0] mem_a;
    int          wcnt, delay, checks, failures;

    jt900h_fetch #(.QW(4)) dut (
        .rst(rst), .clk(clk), .cen(cen), .jmp(jmp), .jmp_addr(jmp_addr),
        .fetched(fetched), .op(op), .op_ok(op_ok), .pc(pc), .bus_addr(bus_addr),
        .bus_rd(bus_rd), .bus_din(bus_din), .bus_ok(bus_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory latches the address at request start, so a dropped word keeps its old data
    always_comb begin
        mem_a   = (wcnt == 0) ? bus_addr : lat;
        bus_din = {mem_a[7:0] + 8'd1, mem_a[7:0]};
        bus_ok  = bus_rd && (wcnt >= delay);
    end
    always @(posedge clk) begin
        if (!bus_rd || (cen && bus_ok)) wcnt <= 0;
        else if (cen) wcnt <= wcnt + 1;
        if (cen && bus_rd && wcnt == 0) lat <= bus_addr;
    end

    typedef struct {
        logic [1:0]  f;
        logic [31:0] op;
        logic        ok;
        logic [23:0] pc;
        logic        rd;
        logic [23:0] addr;
    } vec_t;
    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; wcnt = 0; lat = '0; delay = 0;
        rst = 1'b1; cen = 1'b1; jmp = 1'b0; jmp_addr = '0; fetched = 2'd0;
        tbl = '{
            '{2'd0, 32'h00000000, 1'b0, 24'd0, 1'b1, 24'h000000},
            '{2'd0, 32'h00000100, 1'b0, 24'd0, 1'b0, 24'h000002},
            '{2'd0, 32'h00000100, 1'b0, 24'd0, 1'b0, 24'h000002},
            '{2'd0, 32'h00000100, 1'b0, 24'd0, 1'b1, 24'h000002},
            '{2'd0, 32'h03020100, 1'b1, 24'd0, 1'b0, 24'h000004},
            '{2'd0, 32'h03020100, 1'b1, 24'd0, 1'b0, 24'h000004},
            '{2'd0, 32'h03020100, 1'b1, 24'd0, 1'b1, 24'h000004},
            '{2'd0, 32'h03020100, 1'b1, 24'd0, 1'b0, 24'h000006},
            '{2'd0, 32'h03020100, 1'b1, 24'd0, 1'b0, 24'h000006},
            '{2'd0, 32'h03020100, 1'b1, 24'd0, 1'b1, 24'h000006},
            '{2'd0, 32'h03020100, 1'b1, 24'd0, 1'b0, 24'h000008},
            '{2'd0, 32'h03020100, 1'b1, 24'd0, 1'b0, 24'h000008},
            '{2'd0, 32'h03020100, 1'b1, 24'd0, 1'b0, 24'h000008},
            '{2'd1, 32'h04030201, 1'b1, 24'd1, 1'b0, 24'h000008},
            '{2'd1, 32'h05040302, 1'b1, 24'd2, 1'b0, 24'h000008},
            '{2'd1, 32'h06050403, 1'b1, 24'd3, 1'b1, 24'h000008},
            '{2'd1, 32'h07060504, 1'b1, 24'd4, 1'b0, 24'h00000a},
            '{2'd1, 32'h08070605, 1'b1, 24'd5, 1'b0, 24'h00000a},
            '{2'd1, 32'h09080706, 1'b1, 24'd6, 1'b1, 24'h00000a},
            '{2'd1, 32'h0a090807, 1'b1, 24'd7, 1'b0, 24'h00000c},
            '{2'd1, 32'h0b0a0908, 1'b1, 24'd8, 1'b0, 24'h00000c},
            '{2'd1, 32'h000b0a09, 1'b0, 24'd9, 1'b1, 24'h00000c},
            '{2'd1, 32'h0c0b0a09, 1'b1, 24'd9, 1'b0, 24'h00000e}
        };
        tick;
        chk("rst op", op, 32'h0);
        chk("rst op_ok", 32'(op_ok), 32'h0);
        chk("rst pc", 32'(pc), 32'h0);
        chk("rst bus_rd", 32'(bus_rd), 32'h0);
        chk("rst bus_addr", 32'(bus_addr), 32'h0);
        rst = 1'b0;
        // fill from reset, then retire one byte per cycle
        for (int i = 0; i < 23; i++) begin
            fetched = tbl[i].f;
            tick;
            chk($sformatf("v%0d op", i), op, tbl[i].op);
            chk($sformatf("v%0d op_ok", i), 32'(op_ok), 32'(tbl[i].ok));
            chk($sformatf("v%0d pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("v%0d bus_rd", i), 32'(bus_rd), 32'(tbl[i].rd));
            chk($sformatf("v%0d bus_addr", i), 32'(bus_addr), 32'(tbl[i].addr));
        end
        fetched = 2'd0;
        // odd jump target keeps only the high byte of the first word
        jmp = 1'b1; jmp_addr = 24'h000105;
        tick;
        jmp = 1'b0;
        chk("jmp op_ok", 32'(op_ok), 32'h0);
        chk("jmp pc", 32'(pc), 32'h000105);
        chk("jmp op", op, 32'h0);
        n = 0;
        while (!bus_rd && n < 20) begin tick; n++; end
        chk("jmp req", 32'(bus_rd), 32'h1);
        chk("jmp bus_addr", 32'(bus_addr), 32'h000104);
        n = 0;
        while (!op_ok && n < 40) begin tick; n++; end
        chk("jmp fill ok", 32'(op_ok), 32'h1);
        chk("jmp fill op", op, 32'h08070605);
        chk("jmp fill pc", 32'(pc), 32'h000105);
        tick; tick;
        chk("pre-rst bus_rd", 32'(bus_rd), 32'h1);
        // asynchronous reset mid-cycle while a read is outstanding
        #2 rst = 1'b1;
        #1;
        chk("async bus_rd", 32'(bus_rd), 32'h0);
        chk("async op", op, 32'h0);
        chk("async pc", 32'(pc), 32'h0);
        chk("async bus_addr", 32'(bus_addr), 32'h0);
        @(negedge clk);
        delay = 3;
        rst = 1'b0;
        tick;
        chk("slow req", 32'(bus_rd), 32'h1);
        jmp = 1'b1; jmp_addr = 24'h000310;
        tick;
        jmp = 1'b0;
        chk("drop rd held", 32'(bus_rd), 32'h1);
        chk("drop pc", 32'(pc), 32'h000310);
        n = 0;
        while (bus_rd && n < 20) begin tick; n++; end
        chk("drop done", 32'(bus_rd), 32'h0);
        n = 0;
        while (!bus_rd && n < 20) begin tick; n++; end
        chk("drop next req", 32'(bus_rd), 32'h1);
        chk("drop next addr", 32'(bus_addr), 32'h000310);
        chk("drop no data", op, 32'h0);
        n = 0;
        while (!op_ok && n < 60) begin tick; n++; end
        chk("drop fill ok", 32'(op_ok), 32'h1);
        chk("drop fill op", op, 32'h13121110);
        chk("drop fill pc", 32'(pc), 32'h000310);
        // consume 3 while 2 bytes append at count 6
        rst = 1'b1; delay = 0;
        tick;
        rst = 1'b0;
        repeat (10) tick;
        chk("c6 rd", 32'(bus_rd), 32'h1);
        chk("c6 addr", 32'(bus_addr), 32'h000006);
        chk("c6 op", op, 32'h03020100);
        fetched = 2'd3;
        tick;
        chk("mix op", op, 32'h06050403);
        chk("mix pc", 32'(pc), 32'h000003);
        chk("mix rd", 32'(bus_rd), 32'h0);
        fetched = 2'd1;
        tick;
        chk("mix2 op", op, 32'h07060504);
        chk("mix2 pc", 32'(pc), 32'h000004);
        fetched = 2'd0;
        tick;
        chk("cen req", 32'(bus_rd), 32'h1);
        chk("cen addr", 32'(bus_addr), 32'h000008);
        // bus_ok held high while the clock enable is off
        cen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("cen0 rd %0d", i), 32'(bus_rd), 32'h1);
            chk($sformatf("cen0 addr %0d", i), 32'(bus_addr), 32'h000008);
            chk($sformatf("cen0 op %0d", i), op, 32'h07060504);
        end
        cen = 1'b1;
        tick;
        chk("cen1 rd", 32'(bus_rd), 32'h0);
        chk("cen1 addr", 32'(bus_addr), 32'h00000a);
        fetched = 2'd3;
        tick;
        fetched = 2'd0;
        chk("cen1 op", op, 32'h00090807);
        chk("cen1 pc", 32'(pc), 32'h000007);
        chk("cen1 op_ok", 32'(op_ok), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
